// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : uart_pkg                                                      |
// | Purpose  : Shared types and helpers for the UART receive/transmit path    |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Core clocks per serial bit (integer division).
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_deser_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : uart_rx_deser_if                                              |
// | Purpose  : Valid/ready byte stream from the receiver to the consumer      |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
interface uart_rx_deser_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] RX_DATA;
  logic                 RX_VALID;
  logic                 RX_READY;

  modport master (output RX_DATA, output RX_VALID, input RX_READY);
  modport slave  (input RX_DATA, input RX_VALID, output RX_READY);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : sync_fifo                                                     |
// | Purpose  : Single-clock FIFO, extra-bit pointers, combinational head      |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [WIDTH-1:0]         push_data,
  input  wire logic                     pop,
  output logic      [WIDTH-1:0]         head,
  output logic                          empty,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          overflow
);
  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written (wr == rd slot).
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & ~do_push;
  // Head is forced to zero while empty so it is stable and reset-clean.
  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : uart_rx_deser                                                 |
// | Purpose  : 8N1-style UART receiver with receive FIFO and sticky errors    |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 500_000_000,
  parameter int BAUD_RATE       = 115_200,
  parameter int DATA_BITS       = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  wire logic                          CLK,
  input  wire logic                          RST,
  input  wire logic                          UART_RX_DSER,
  input  wire logic                          CLR_ERR,
  uart_rx_deser_if.master                    rx,
  output logic                               FRAME_ERR,
  output logic                               OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0]        FIFO_COUNT
);
  localparam int CPB   = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_BITS);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_deser: clocks per bit below 4");
    end
  endgenerate

  logic                 sync1, sync2, sync_d;
  logic                 fall;
  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt, cnt_next;
  logic [BIT_W-1:0]     bit_idx, bit_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 push;
  logic                 frame_evt;
  logic                 overflow_evt;
  logic                 fifo_empty;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1  <= UART_IDLE_LEVEL;
      sync2  <= UART_IDLE_LEVEL;
      sync_d <= UART_IDLE_LEVEL;
    end else begin
      sync1  <= UART_RX_DSER;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign fall = sync_d & ~sync2;

  // Frame state, bit timing counter, bit index and shift register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
    end
  end

  // Next-state logic: start is checked at half a bit, data/stop at full bits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    push       = 1'b0;
    frame_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt == CNT_W'(HALF - 1)) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = sync2 ? IDLE : DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_next   = '0;
          shift_next = {sync2, shift[DATA_BITS-1:1]};
          if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 1'b1;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_W'(CPB - 1)) begin
          cnt_next = '0;
          if (sync2) begin
            push       = 1'b1;
            state_next = IDLE;
          end else begin
            frame_evt  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        // Break holds here so a long low line reports only one error.
        if (sync2) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sticky error flags; a new event beats a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      if (frame_evt)         FRAME_ERR <= 1'b1;
      else if (CLR_ERR)      FRAME_ERR <= 1'b0;
      if (overflow_evt)      OVERRUN   <= 1'b1;
      else if (CLR_ERR)      OVERRUN   <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push),
    .push_data (shift),
    .pop       (rx.RX_READY),
    .head      (rx.RX_DATA),
    .empty     (fifo_empty),
    .count     (FIFO_COUNT),
    .overflow  (overflow_evt)
  );

  assign rx.RX_VALID = ~fifo_empty;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deser.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : tb_uart_rx_deser                                              |
// | Purpose  : Scoreboard bench for the UART receive deserializer            |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;
  localparam int CPB = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       line    = 1'b1;
  logic       clr_err = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic [4:0] fifo_count;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         lat;
  logic       valid_after;

  uart_rx_deser_if #(.DATA_BITS(8)) rx_if ();

  uart_rx_deser #(
    .CLOCK_FREQUENCY (1_600_000),
    .BAUD_RATE       (100_000),
    .DATA_BITS       (8),
    .FIFO_DEPTH      (16)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .UART_RX_DSER (line),
    .CLR_ERR      (clr_err),
    .rx           (rx_if),
    .FRAME_ERR    (frame_err),
    .OVERRUN      (overrun),
    .FIFO_COUNT   (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Monitor: every accepted byte must match the next expected byte.
  always @(negedge clk) begin
    if (!rst && rx_if.RX_VALID && rx_if.RX_READY) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rx_unexpected: actual 0x%0h required no byte", rx_if.RX_DATA);
      end else begin
        check("rx_data", rx_if.RX_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one frame starting now; line is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    line = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      tick(CPB);
    end
    line = stop;
    tick(CPB);
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 2000; i++) begin
      if (fifo_count == 0) break;
      tick(1);
    end
    check(name, fifo_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.RX_READY = 1'b0;
    tick(3);
    check("rst_valid", rx_if.RX_VALID, 0);
    check("rst_data", rx_if.RX_DATA, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_count", fifo_count, 0);
    rst = 1'b0;
    tick(4);

    // Single frame with latency measurement
    rx_if.RX_READY = 1'b1;
    exp_q.push_back(8'hA5);
    lat = 0;
    valid_after = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 400; i++) begin
          @(posedge clk);
          #1;
          if (rx_if.RX_VALID) begin
            lat = i;
            @(posedge clk);
            #1;
            valid_after = rx_if.RX_VALID;
            break;
          end
        end
      end
    join
    check("latency", lat, 155);
    check("pop_one_cycle", valid_after, 0);
    check("single_frame_err", frame_err, 0);
    check("single_overrun", overrun, 0);

    // Glitch rejection, followed by a good frame
    line = 1'b0;
    tick(5);
    line = 1'b1;
    tick(3 * CPB);
    check("glitch_count", fifo_count, 0);
    check("glitch_frame_err", frame_err, 0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b1);
    tick(CPB);
    wait_empty("glitch_then_frame");

    // Framing error with a long break
    send_frame(8'h3C, 1'b0);
    tick(2 * CPB);
    check("ferr_set", frame_err, 1);
    check("ferr_count", fifo_count, 0);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ferr_cleared", frame_err, 0);
    tick(17 * CPB);
    line = 1'b1;
    tick(2 * CPB);
    check("ferr_single_event", frame_err, 0);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tick(CPB);
    wait_empty("ferr_recover");

    // Overrun: 17 bytes into a 16-entry FIFO
    rx_if.RX_READY = 1'b0;
    for (int b = 0; b < 17; b++) begin
      if (b < 16) exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    tick(2);
    check("ovr_count", fifo_count, 16);
    check("ovr_flag", overrun, 1);
    rx_if.RX_READY = 1'b1;
    wait_empty("ovr_drain");
    check("ovr_queue", exp_q.size(), 0);
    rx_if.RX_READY = 1'b0;
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Push and pop in the same cycle while full
    for (int b = 8'h20; b < 8'h30; b++) begin
      exp_q.push_back(8'(b));
      send_frame(8'(b), 1'b1);
    end
    tick(2);
    check("full_count", fifo_count, 16);
    exp_q.push_back(8'h30);
    fork
      send_frame(8'h30, 1'b1);
      begin
        tick(154);
        rx_if.RX_READY = 1'b1;
        tick(1);
        rx_if.RX_READY = 1'b0;
      end
    join
    check("pp_count", fifo_count, 16);
    check("pp_overrun", overrun, 0);
    rx_if.RX_READY = 1'b1;
    wait_empty("pp_drain");
    check("pp_queue", exp_q.size(), 0);

    // Reset during data bit 4 with one byte already buffered
    rx_if.RX_READY = 1'b0;
    send_frame(8'h77, 1'b1);
    tick(2);
    check("pre_rst_count", fifo_count, 1);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        tick(5 * CPB + 8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_valid", rx_if.RX_VALID, 0);
        check("mid_rst_data", rx_if.RX_DATA, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
      end
    join
    tick(2 * CPB);
    check("mid_rst_no_push", fifo_count, 0);
    rx_if.RX_READY = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(CPB);
    wait_empty("post_rst_frame");

    check("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
